// File: rtl/pixel_array_ctrl.sv
// -----------------------------------------------------------------------------
// pixel_array_ctrl
//
// Global-shutter sequencer for the pixel array. Runs one frame as
// ERASE -> EXPOSE -> CONVERT -> READ(row 0 .. H-1), with a single idle GAP
// cycle after every phase and after every row. During CONVERT it produces
// the shared ADC ramp; during READ it steps the row select.
//
// Ports
//   clk            system clock, rising edge
//   reset          synchronous, active-low reset
//   start          level; starts a frame when seen high in IDLE
//   continuous     sampled in the final GAP; high chains straight into ERASE
//   abort          high at any edge returns the block to IDLE
//   expose_time    exposure length in cycles, latched on ERASE entry (0 -> 1)
//   erase, expose, convert, read   phase strobes to the array (never overlap)
//   row_sel        row being read (held through the GAP after each row)
//   pixel_counter  ADC ramp, 0 .. 2^COUNTER_WIDTH-1 across CONVERT, else 0
//   busy           high whenever not IDLE
//   frame_done     one-cycle pulse in the final GAP of a frame
// -----------------------------------------------------------------------------
module pixel_array_ctrl #(
   parameter int PIXEL_ARRAY_HEIGHT = 2,
   parameter int COUNTER_WIDTH      = 8,
   parameter int EXPOSE_WIDTH       = 8,
   parameter int ERASE_CYCLES       = 5,
   parameter int READ_CYCLES        = 5,
   localparam int ROW_W = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     continuous,
   input  logic                     abort,
   input  logic [EXPOSE_WIDTH-1:0]  expose_time,
   output logic                     erase,
   output logic                     expose,
   output logic                     convert,
   output logic                     read,
   output logic [ROW_W-1:0]         row_sel,
   output logic [COUNTER_WIDTH-1:0] pixel_counter,
   output logic                     busy,
   output logic                     frame_done
);

   // Phase-cycle counter must hold the longest phase length.
   localparam int CONV_LEN = 1 << COUNTER_WIDTH;
   localparam int EXP_MAX  = 1 << EXPOSE_WIDTH;
   localparam int MAX_A    = (CONV_LEN > EXP_MAX) ? CONV_LEN : EXP_MAX;
   localparam int MAX_B    = (ERASE_CYCLES > READ_CYCLES) ? ERASE_CYCLES : READ_CYCLES;
   localparam int MAX_LEN  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CNT_W    = $clog2(MAX_LEN + 1);

   localparam logic [CNT_W-1:0] ERASE_LAST = CNT_W'(ERASE_CYCLES - 1);
   localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(READ_CYCLES - 1);
   localparam logic [CNT_W-1:0] CONV_LAST  = CNT_W'(CONV_LEN - 1);
   localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(PIXEL_ARRAY_HEIGHT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ERASE, S_EXPOSE, S_CONVERT, S_READ, S_GAP
   } state_t;

   state_t                  state;
   state_t                  after;     // phase that the current GAP follows
   logic [CNT_W-1:0]        cnt;       // cycles spent in the current phase
   logic [EXPOSE_WIDTH-1:0] exp_last;  // latched exposure length minus one

   always_ff @(posedge clk) begin
      // NOTE: every register here, outputs included, is state updated with
      // non-blocking assignments so all of them see the same pre-edge values.
      if (!reset || abort) begin
         state         <= S_IDLE;
         after         <= S_IDLE;
         cnt           <= '0;
         exp_last      <= '0;
         erase         <= 1'b0;
         expose        <= 1'b0;
         convert       <= 1'b0;
         read          <= 1'b0;
         row_sel       <= '0;
         pixel_counter <= '0;
         busy          <= 1'b0;
         frame_done    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state    <= S_ERASE;
                  erase    <= 1'b1;
                  busy     <= 1'b1;
                  cnt      <= '0;
                  exp_last <= (expose_time == '0) ? '0 : expose_time - EXPOSE_WIDTH'(1);
               end
            end

            S_ERASE: begin
               if (cnt == ERASE_LAST) begin
                  erase <= 1'b0;
                  after <= S_ERASE;
                  state <= S_GAP;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            S_EXPOSE: begin
               if (cnt == CNT_W'(exp_last)) begin
                  expose <= 1'b0;
                  after  <= S_EXPOSE;
                  state  <= S_GAP;
                  cnt    <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            S_CONVERT: begin
               // Ramp stops at all-ones and is cleared on exit, so it never wraps.
               if (cnt == CONV_LAST) begin
                  convert       <= 1'b0;
                  pixel_counter <= '0;
                  after         <= S_CONVERT;
                  state         <= S_GAP;
                  cnt           <= '0;
               end else begin
                  cnt           <= cnt + CNT_W'(1);
                  pixel_counter <= pixel_counter + COUNTER_WIDTH'(1);
               end
            end

            S_READ: begin
               if (cnt == READ_LAST) begin
                  read       <= 1'b0;
                  after      <= S_READ;
                  state      <= S_GAP;
                  cnt        <= '0;
                  // The GAP after the last row is the frame's final cycle.
                  frame_done <= (row_sel == LAST_ROW);
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            S_GAP: begin
               cnt <= '0;
               case (after)
                  S_ERASE: begin
                     expose <= 1'b1;
                     state  <= S_EXPOSE;
                  end
                  S_EXPOSE: begin
                     convert <= 1'b1;
                     state   <= S_CONVERT;
                  end
                  S_CONVERT: begin
                     read    <= 1'b1;
                     row_sel <= '0;
                     state   <= S_READ;
                  end
                  S_READ: begin
                     if (frame_done) begin
                        frame_done <= 1'b0;
                        row_sel    <= '0;
                        if (continuous) begin
                           state    <= S_ERASE;
                           erase    <= 1'b1;
                           exp_last <= (expose_time == '0) ? '0 : expose_time - EXPOSE_WIDTH'(1);
                        end else begin
                           state <= S_IDLE;
                           busy  <= 1'b0;
                        end
                     end else begin
                        row_sel <= row_sel + ROW_W'(1);
                        read    <= 1'b1;
                        state   <= S_READ;
                     end
                  end
                  default: begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end
               endcase
            end

            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pixel_array_ctrl
//
// Self-checking bench for pixel_array_ctrl with H=4, COUNTER_WIDTH=4, E=5, R=5.
// A frame-position model predicts every output from the documented timing
// formulas; table vectors, hand-written sequences and random stimulus are all
// compared against it every cycle, alongside the strobe invariants.
// -----------------------------------------------------------------------------
module tb_pixel_array_ctrl;

   localparam int H  = 4;
   localparam int CW = 4;
   localparam int EW = 8;
   localparam int E  = 5;
   localparam int R  = 5;
   localparam int C  = 1 << CW;
   localparam int RW = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          continuous = 1'b0;
   logic          abort = 1'b0;
   logic [EW-1:0] expose_time = 8'd10;
   logic          erase, expose, convert, read;
   logic [RW-1:0] row_sel;
   logic [CW-1:0] pixel_counter;
   logic          busy, frame_done;

   pixel_array_ctrl #(
      .PIXEL_ARRAY_HEIGHT (H),
      .COUNTER_WIDTH      (CW),
      .EXPOSE_WIDTH       (EW),
      .ERASE_CYCLES       (E),
      .READ_CYCLES        (R)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .continuous    (continuous),
      .abort         (abort),
      .expose_time   (expose_time),
      .erase         (erase),
      .expose        (expose),
      .convert       (convert),
      .read          (read),
      .row_sel       (row_sel),
      .pixel_counter (pixel_counter),
      .busy          (busy),
      .frame_done    (frame_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   logic [3:0] prev_s = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s cycle %0d actual %0h required %0h", name, cyc, act, req);
      end
   endtask

   // ---------------- reference model: position within the frame -------------
   int m_p = 0;   // 0 = idle, 1..L = cycle number within the current frame
   int m_t = 1;   // latched exposure

   function automatic int frame_len(input int t);
      return E + 3 + t + C + H * (R + 1);
   endfunction

   task automatic model_edge(input logic st, input logic cont, input logic ab,
                             input logic rst, input logic [EW-1:0] et);
      if (!rst || ab) m_p = 0;
      else if (m_p == 0) begin
         if (st) begin
            m_p = 1;
            m_t = (et == 0) ? 1 : int'(et);
         end
      end else if (m_p == frame_len(m_t)) begin
         if (cont) begin
            m_p = 1;
            m_t = (et == 0) ? 1 : int'(et);
         end else m_p = 0;
      end else m_p++;
   endtask

   // {erase, expose, convert, read, row_sel, pixel_counter, busy, frame_done}
   function automatic logic [11:0] expect_out(input int p, input int t);
      logic er, ex, cv, rd, fd;
      int   pc, row, q;
      if (p == 0) return '0;
      er  = (p >= 1) && (p <= E);
      ex  = (p >= E + 2) && (p <= E + 1 + t);
      cv  = (p >= E + 3 + t) && (p <= E + 2 + t + C);
      pc  = cv ? p - (E + 3 + t) : 0;
      q   = p - (E + 4 + t + C);
      rd  = 1'b0;
      row = 0;
      if (q >= 0) begin
         row = q / (R + 1);
         rd  = (q % (R + 1)) < R;
      end
      fd = (p == frame_len(t));
      return {er, ex, cv, rd, RW'(row), CW'(pc), 1'b1, fd};
   endfunction

   function automatic logic [11:0] dut_out();
      return {erase, expose, convert, read, row_sel, pixel_counter, busy, frame_done};
   endfunction

   // One clock: drive inputs, advance DUT and model, compare after the edge.
   task automatic step(input logic st, input logic cont, input logic ab,
                       input logic rst, input logic [EW-1:0] et);
      logic [3:0] s;
      start = st; continuous = cont; abort = ab; reset = rst; expose_time = et;
      @(posedge clk);
      model_edge(st, cont, ab, rst, et);
      cyc++;
      #1;
      check("model", 32'(dut_out()), 32'(expect_out(m_p, m_t)));
      s = {erase, expose, convert, read};
      check("onehot", 32'($onehot0(s)), 32'd1);
      if (prev_s != 0 && s != 0) check("strobe_gap", 32'(s), 32'(prev_s));
      if (!convert) check("pcnt_outside", 32'(pixel_counter), 32'd0);
      prev_s = s;
   endtask

   task automatic do_reset();
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0, 8'd10);
         check("reset_state", 32'(dut_out()), 32'd0);
      end
      step(1'b0, 1'b0, 1'b0, 1'b1, 8'd10);
   endtask

   // ---------------- table of single-frame vectors --------------------------
   typedef struct {
      int et;         // expose_time at start
      int change_at;  // cycle from which expose_time changes (-1 = never)
      int new_et;
      int exp_len;    // expected expose strobe length
      int done_at;    // expected frame_done cycle
   } vec_t;

   vec_t vecs [4];

   initial begin
      int done_cyc, exp_cnt, ndone;
      int dones [3];
      int rises [2];
      int nrise;
      logic [EW-1:0] et_now;

      vecs[0] = '{et: 10,  change_at: -1, new_et: 0, exp_len: 10,  done_at: 58};
      vecs[1] = '{et: 0,   change_at: -1, new_et: 0, exp_len: 1,   done_at: 49};
      vecs[2] = '{et: 255, change_at: -1, new_et: 0, exp_len: 255, done_at: 303};
      vecs[3] = '{et: 10,  change_at: 10, new_et: 3, exp_len: 10,  done_at: 58};

      for (int i = 0; i < 4; i++) begin
         do_reset();
         cyc = 0;
         step(1'b1, 1'b0, 1'b0, 1'b1, EW'(vecs[i].et));
         done_cyc = -1;
         exp_cnt  = 0;
         while (done_cyc < 0 && cyc < 400) begin
            if (expose) exp_cnt++;
            et_now = (vecs[i].change_at >= 0 && cyc >= vecs[i].change_at) ?
                     EW'(vecs[i].new_et) : EW'(vecs[i].et);
            step(1'b0, 1'b0, 1'b0, 1'b1, et_now);
            if (frame_done) done_cyc = cyc;
            if (i == 0 && cyc == 18) check("conv_first", 32'({convert, pixel_counter}), 32'h10);
            if (i == 0 && cyc == 33) check("conv_last", 32'({convert, pixel_counter}), 32'h1f);
            if (i == 0 && cyc == 35) check("row0_start", 32'({read, row_sel}), 32'h4);
            if (i == 0 && cyc == 53) check("row3_start", 32'({read, row_sel}), 32'h7);
         end
         check("frame_done_cycle", 32'(done_cyc), 32'(vecs[i].done_at));
         check("expose_length", 32'(exp_cnt), 32'(vecs[i].exp_len));
         step(1'b0, 1'b0, 1'b0, 1'b1, 8'd10);
         check("busy_after_frame", 32'(busy), 32'd0);
      end

      // ---------------- continuous: three chained frames, start held while busy
      do_reset();
      cyc = 0;
      step(1'b1, 1'b1, 1'b0, 1'b1, 8'd10);
      ndone = 0;
      nrise = 0;
      while (cyc < 200) begin
         logic prev_er;
         prev_er = erase;
         step(busy, (ndone < 3), 1'b0, 1'b1, 8'd10);
         if (frame_done) begin
            if (ndone < 3) dones[ndone] = cyc;
            ndone++;
         end
         if (erase && !prev_er) begin
            if (nrise < 2) rises[nrise] = cyc;
            nrise++;
         end
      end
      check("cont_done_count", 32'(ndone), 32'd3);
      check("cont_rise_count", 32'(nrise), 32'd2);
      check("cont_done0", 32'(dones[0]), 32'd58);
      check("cont_spacing1", 32'(dones[1] - dones[0]), 32'd58);
      check("cont_spacing2", 32'(dones[2] - dones[1]), 32'd58);
      check("cont_erase2", 32'(rises[0]), 32'd59);
      check("cont_erase3", 32'(rises[1]), 32'd117);

      // ---------------- abort during convert ---------------------------------
      do_reset();
      cyc = 0;
      step(1'b1, 1'b0, 1'b0, 1'b1, 8'd10);
      while (cyc < 25) step(1'b0, 1'b0, 1'b0, 1'b1, 8'd10);
      step(1'b0, 1'b0, 1'b1, 1'b1, 8'd10);
      check("abort_outputs", 32'(dut_out()), 32'd0);
      ndone = 0;
      for (int k = 0; k < 40; k++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1, 8'd10);
         if (frame_done) ndone++;
      end
      check("abort_no_done", 32'(ndone), 32'd0);
      // abort and start together in IDLE: stays idle
      step(1'b1, 1'b0, 1'b1, 1'b1, 8'd10);
      check("abort_beats_start", 32'({busy, erase}), 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 8'd10);
      check("still_idle", 32'(busy), 32'd0);
      cyc = 0;
      step(1'b1, 1'b0, 1'b0, 1'b1, 8'd10);
      done_cyc = -1;
      while (done_cyc < 0 && cyc < 100) begin
         step(1'b0, 1'b0, 1'b0, 1'b1, 8'd10);
         if (frame_done) done_cyc = cyc;
      end
      check("frame_after_abort", 32'(done_cyc), 32'd58);

      // ---------------- reset during row 2 -----------------------------------
      do_reset();
      cyc = 0;
      step(1'b1, 1'b0, 1'b0, 1'b1, 8'd10);
      while (cyc < 48) step(1'b0, 1'b0, 1'b0, 1'b1, 8'd10);
      check("in_row2", 32'({read, row_sel}), 32'h6);
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0, 8'd10);
         check("reset_mid_read", 32'(dut_out()), 32'd0);
      end
      step(1'b0, 1'b0, 1'b0, 1'b1, 8'd10);
      check("idle_after_reset", 32'(busy), 32'd0);

      // ---------------- randomized stimulus against the model ----------------
      for (int k = 0; k < 3000; k++) begin
         logic st, cont, ab, rst;
         logic [EW-1:0] et;
         rst  = ($urandom_range(0, 399) != 0);
         ab   = ($urandom_range(0, 149) == 0);
         st   = ($urandom_range(0, 3) == 0);
         cont = $urandom_range(0, 1) == 1;
         et   = ($urandom_range(0, 7) == 0) ? EW'($urandom_range(0, 255))
                                              : EW'($urandom_range(0, 20));
         step(st, cont, ab, rst, et);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
